// File: rtl/lsu_misalign_splitter_pkg.sv
// rtl/lsu_misalign_splitter_pkg.sv - shared widths, funct3 codes and FSM states for the LSU splitter
package lsu_misalign_splitter_pkg;

  localparam int XLEN = 32;
  localparam int ALEN = 32;

  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_HALF = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;

  typedef enum logic [1:0] {LSU_IDLE, LSU_LD_HI, LSU_ST_BYTE} lsu_state_t;

  // Byte accesses can never straddle a word, so only half/word sizes are checked.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3 == F3_HALF || f3 == F3_LHU) && off[0]) || (f3 == F3_WORD && off != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_misalign_splitter_if.sv
// rtl/lsu_misalign_splitter_if.sv - MEM-stage request/response bundle between pipeline and LSU
interface lsu_misalign_splitter_if;
  import lsu_misalign_splitter_pkg::*;

  logic            req_valid;
  logic            req_write;
  logic [2:0]      req_funct3;
  logic [ALEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            stall;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  stall, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output stall, resp_valid, resp_rdata
  );

endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - shifts a {hi,lo} word pair by the byte offset and sign/zero-extends the load
module lsu_load_align
  import lsu_misalign_splitter_pkg::*;
(
  input  logic [2*XLEN-1:0] data_i,
  input  logic [1:0]        offset_i,
  input  logic [2:0]        funct3_i,
  output logic [XLEN-1:0]   rdata_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = XLEN'(data_i >> {offset_i, 3'b000});

  always_comb begin
    case (funct3_i)
      F3_BYTE: rdata_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LBU:  rdata_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HALF: rdata_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LHU:  rdata_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_misalign_splitter.sv
// rtl/lsu_misalign_splitter.sv - splits misaligned loads/stores into aligned DataMemory accesses (LSU_MISALIGN_TRAP_EN: trap instead)
module lsu_misalign_splitter
  import lsu_misalign_splitter_pkg::*;
#(
  parameter logic [ALEN-1:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lsu_misalign_splitter_if.slave pipe_if,
  output logic                  mem_write_o,
  output logic [2:0]            mem_funct3_o,
  output logic [ALEN-1:0]       mem_addr_o,
  output logic [XLEN-1:0]       mem_wdata_o,
  input  logic [XLEN-1:0]       mem_rdata_i
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                  misalign_trap_o
`endif
);

  lsu_state_t      state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [ALEN-1:0] addr_q, addr_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            write_q, write_d;

  logic            split_req;
  logic            last_byte;
  logic [ALEN-1:0] word_base;
  logic [2*XLEN-1:0] al_data;
  logic [1:0]      al_off;
  logic [2:0]      al_f3;

  // MMIO space is passed through unsplit: device registers must not see byte-wise replays.
  assign split_req = pipe_if.req_valid && (pipe_if.req_addr < MMIO_BASE)
                     && is_misaligned(pipe_if.req_funct3, pipe_if.req_addr[1:0]);
  assign word_base = {addr_q[ALEN-1:2], 2'b00};
  assign last_byte = (f3_q == F3_WORD) ? (cnt_q == 2'd3) : (cnt_q == 2'd1);

  lsu_load_align u_align (
    .data_i   (al_data),
    .offset_i (al_off),
    .funct3_i (al_f3),
    .rdata_o  (pipe_if.resp_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      cnt_q   <= 2'd0;
      lo_q    <= '0;
      addr_q  <= '0;
      f3_q    <= F3_BYTE;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    lo_d               = lo_q;
    addr_d             = addr_q;
    f3_d               = f3_q;
    wdata_d            = wdata_q;
    write_d            = write_q;
    mem_write_o        = pipe_if.req_valid & pipe_if.req_write;
    mem_funct3_o       = pipe_if.req_funct3;
    mem_addr_o         = pipe_if.req_addr;
    mem_wdata_o        = pipe_if.req_wdata;
    pipe_if.stall      = 1'b0;
    pipe_if.resp_valid = pipe_if.req_valid;
    al_data            = {{XLEN{1'b0}}, mem_rdata_i};
    al_off             = 2'b00;
    al_f3              = F3_WORD;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_trap_o    = 1'b0;
`endif

    case (state_q)
      LSU_IDLE: begin
        if (split_req) begin
`ifdef LSU_MISALIGN_TRAP_EN
          misalign_trap_o    = 1'b1;
          mem_write_o        = 1'b0;
          pipe_if.resp_valid = 1'b0;
`else
          addr_d             = pipe_if.req_addr;
          f3_d               = pipe_if.req_funct3;
          wdata_d            = pipe_if.req_wdata;
          write_d            = pipe_if.req_write;
          pipe_if.stall      = 1'b1;
          pipe_if.resp_valid = 1'b0;
          if (pipe_if.req_write) begin
            mem_funct3_o = F3_BYTE;
            mem_write_o  = 1'b1;
            cnt_d        = 2'd1;
            state_d      = LSU_ST_BYTE;
          end else begin
            mem_addr_o   = {pipe_if.req_addr[ALEN-1:2], 2'b00};
            mem_funct3_o = F3_WORD;
            mem_write_o  = 1'b0;
            lo_d         = mem_rdata_i;
            state_d      = LSU_LD_HI;
          end
`endif
        end
      end
      LSU_LD_HI: begin
        mem_addr_o         = word_base + ALEN'(4);
        mem_funct3_o       = F3_WORD;
        mem_write_o        = write_q;
        mem_wdata_o        = wdata_q;
        pipe_if.resp_valid = 1'b1;
        al_data            = {mem_rdata_i, lo_q};
        al_off             = addr_q[1:0];
        al_f3              = f3_q;
        state_d            = LSU_IDLE;
      end
      LSU_ST_BYTE: begin
        // Latched copies drive the bus so a dropped req_valid cannot abort a half-written store.
        mem_addr_o         = addr_q + ALEN'(cnt_q);
        mem_funct3_o       = F3_BYTE;
        mem_wdata_o        = wdata_q >> {cnt_q, 3'b000};
        mem_write_o        = write_q;
        pipe_if.stall      = ~last_byte;
        pipe_if.resp_valid = last_byte;
        if (last_byte) begin
          state_d = LSU_IDLE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d   = cnt_q + 2'd1;
        end
      end
      default: state_d = LSU_IDLE;
    endcase

    if (!rst_n) begin
      pipe_if.stall      = 1'b0;
      pipe_if.resp_valid = 1'b0;
      mem_write_o        = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_trap_o    = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_misalign_splitter.sv
// tb/tb_lsu_misalign_splitter.sv - scoreboard bench for lsu_misalign_splitter with a byte-array DataMemory model
module tb_lsu_misalign_splitter;
  import lsu_misalign_splitter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_misalign_splitter_if pipe_if();
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  lsu_misalign_splitter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_if      (pipe_if),
    .mem_write_o  (mem_write),
    .mem_funct3_o (mem_funct3),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign_trap_o (misalign_trap)
`endif
  );

  // DataMemory model: 4 KiB byte array, combinational read, write on posedge.
  logic [7:0]  mem [0:4095];
  logic        pre_we = 1'b0;
  logic [11:0] pre_a = '0;
  logic [31:0] pre_d = '0;
  logic [11:0] ra, wa;
  assign ra = mem_addr[11:0];
  assign wa = {mem_addr[11:2], 2'b00};

  always_comb begin
    case (mem_funct3)
      F3_BYTE: mem_rdata = {{24{mem[ra][7]}}, mem[ra]};
      F3_LBU:  mem_rdata = {24'h0, mem[ra]};
      F3_HALF: mem_rdata = {{16{mem[ra+12'd1][7]}}, mem[ra+12'd1], mem[ra]};
      F3_LHU:  mem_rdata = {16'h0, mem[ra+12'd1], mem[ra]};
      default: mem_rdata = {mem[wa+12'd3], mem[wa+12'd2], mem[wa+12'd1], mem[wa]};
    endcase
  end

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_a]        <= pre_d[7:0];
      mem[pre_a+12'd1]  <= pre_d[15:8];
      mem[pre_a+12'd2]  <= pre_d[23:16];
      mem[pre_a+12'd3]  <= pre_d[31:24];
    end else if (mem_write) begin
      mem[ra] <= mem_wdata[7:0];
      if (mem_funct3 != F3_BYTE) mem[ra+12'd1] <= mem_wdata[15:8];
      if (mem_funct3 == F3_WORD) begin
        mem[ra+12'd2] <= mem_wdata[23:16];
        mem[ra+12'd3] <= mem_wdata[31:24];
      end
    end
  end

  typedef struct { logic is_load; logic [31:0] rdata; } resp_t;
  typedef struct { logic [31:0] addr; logic [2:0] f3; logic [31:0] data; } wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];
  resp_t rexp;
  wr_t   wexp;
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [11:0] a);
    return {mem[a+12'd3], mem[a+12'd2], mem[a+12'd1], mem[a]};
  endfunction

  // Monitor: every DataMemory write and every response is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_write) begin
        if (wr_q.size() == 0) check("unexpected_write", {mem_addr, mem_wdata}, 64'h0);
        else begin
          wexp = wr_q.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(wexp.addr));
          check("wr_f3", 64'(mem_funct3), 64'(wexp.f3));
          check("wr_data", 64'(mem_wdata), 64'(wexp.data));
        end
      end
      if (pipe_if.resp_valid) begin
        if (resp_q.size() == 0) check("unexpected_resp", 64'(pipe_if.resp_rdata), 64'hffff_ffff_0000_0000);
        else begin
          rexp = resp_q.pop_front();
          if (rexp.is_load) check("resp_rdata", 64'(pipe_if.resp_rdata), 64'(rexp.rdata));
          else check("store_retire_write", 64'(mem_write), 64'd1);
        end
      end
    end
  end

  task automatic push_ld(input logic [31:0] d);
    resp_q.push_back('{1'b1, d});
  endtask

  task automatic push_st();
    resp_q.push_back('{1'b0, 32'h0});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    wr_q.push_back('{a, f3, d});
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic issue(input string name, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input int exp_stalls);
    int  stalls = 0;
    logic done = 1'b0;
    pipe_if.req_valid = 1'b1; pipe_if.req_write = w; pipe_if.req_funct3 = f3;
    pipe_if.req_addr = a; pipe_if.req_wdata = d;
    for (int k = 0; k < 8 && !done; k++) begin
      @(negedge clk);
      if (!pipe_if.stall) done = 1'b1;
      else begin
        stalls++;
        @(posedge clk); #1;
      end
    end
    check({name, "_completes"}, 64'(done), 64'd1);
    check({name, "_stalls"}, 64'(stalls), 64'(exp_stalls));
    @(posedge clk); #1;
    pipe_if.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    pipe_if.req_valid = 1'b1; pipe_if.req_write = 1'b1; pipe_if.req_funct3 = F3_WORD;
    pipe_if.req_addr = 32'h100; pipe_if.req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_stall", 64'(pipe_if.stall), 64'd0);
    check("rst_resp_valid", 64'(pipe_if.resp_valid), 64'd0);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    pipe_if.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    preload(12'h100, 32'h1122_3344);
    push_ld(32'h1122_3344);
    issue("lw_aligned", 1'b0, F3_WORD, 32'h100, 32'h0, 0);

    preload(12'h100, 32'h8033_2211);
    push_ld(32'hFFFF_8033);
    issue("lh_aligned", 1'b0, F3_HALF, 32'h102, 32'h0, 0);
    push_ld(32'hFFFF_FF80);
    issue("lb_odd", 1'b0, F3_BYTE, 32'h103, 32'h0, 0);
    push_ld(32'h0000_0080);
    issue("lbu_odd", 1'b0, F3_LBU, 32'h103, 32'h0, 0);

    push_wr(32'h300, F3_WORD, 32'hCAFE_BABE);
    push_st();
    issue("sw_aligned", 1'b1, F3_WORD, 32'h300, 32'hCAFE_BABE, 0);

    push_wr(32'h8000_0001, F3_WORD, 32'h0BAD_F00D);
    push_st();
    issue("sw_mmio", 1'b1, F3_WORD, 32'h8000_0001, 32'h0BAD_F00D, 0);

`ifdef LSU_MISALIGN_TRAP_EN
    pipe_if.req_valid = 1'b1; pipe_if.req_write = 1'b0; pipe_if.req_funct3 = F3_WORD;
    pipe_if.req_addr = 32'h101;
    @(negedge clk);
    check("trap_lw", 64'(misalign_trap), 64'd1);
    check("trap_lw_stall", 64'(pipe_if.stall), 64'd0);
    check("trap_lw_resp", 64'(pipe_if.resp_valid), 64'd0);
    pipe_if.req_write = 1'b1; pipe_if.req_addr = 32'h202;
    @(negedge clk);
    check("trap_sw", 64'(misalign_trap), 64'd1);
    check("trap_sw_write", 64'(mem_write), 64'd0);
    @(posedge clk); #1;
    pipe_if.req_valid = 1'b0;
    push_ld(32'h8033_2211);
    issue("lw_after_trap", 1'b0, F3_WORD, 32'h100, 32'h0, 0);
`else
    preload(12'h100, 32'h4433_2211);
    preload(12'h104, 32'h8877_6655);
    push_ld(32'h5544_3322);
    issue("lw_off1", 1'b0, F3_WORD, 32'h101, 32'h0, 1);
    push_ld(32'h6655_4433);
    issue("lw_off2", 1'b0, F3_WORD, 32'h102, 32'h0, 1);
    push_ld(32'h7766_5544);
    issue("lw_off3", 1'b0, F3_WORD, 32'h103, 32'h0, 1);

    preload(12'h100, 32'h8033_2211);
    preload(12'h104, 32'h8877_66FF);
    push_ld(32'hFFFF_FF80);
    issue("lh_split", 1'b0, F3_HALF, 32'h103, 32'h0, 1);
    push_ld(32'h0000_FF80);
    issue("lhu_split", 1'b0, F3_LHU, 32'h103, 32'h0, 1);
    push_ld(32'h0000_3322);
    issue("lh_off1", 1'b0, F3_HALF, 32'h101, 32'h0, 1);

    preload(12'h200, 32'h9988_7766);
    preload(12'h204, 32'h5544_3322);
    push_wr(32'h202, F3_BYTE, 32'hA1B2_C3D4);
    push_wr(32'h203, F3_BYTE, 32'h00A1_B2C3);
    push_wr(32'h204, F3_BYTE, 32'h0000_A1B2);
    push_wr(32'h205, F3_BYTE, 32'h0000_00A1);
    push_st();
    issue("sw_split", 1'b1, F3_WORD, 32'h202, 32'hA1B2_C3D4, 3);
    check("sw_word200", 64'(word_at(12'h200)), 64'h0000_0000_C3D4_7766);
    check("sw_word204", 64'(word_at(12'h204)), 64'h0000_0000_5544_A1B2);

    push_wr(32'h205, F3_BYTE, 32'h0000_BEEF);
    push_wr(32'h206, F3_BYTE, 32'h0000_00BE);
    push_st();
    issue("sh_split", 1'b1, F3_HALF, 32'h205, 32'h0000_BEEF, 1);
    check("sh_word204", 64'(word_at(12'h204)), 64'h0000_0000_55BE_EFB2);

    preload(12'h800, 32'h0);
    push_wr(32'h801, F3_BYTE, 32'h0000_1234);
    pipe_if.req_valid = 1'b1; pipe_if.req_write = 1'b1; pipe_if.req_funct3 = F3_HALF;
    pipe_if.req_addr = 32'h801; pipe_if.req_wdata = 32'h0000_1234;
    @(negedge clk);
    check("sh_rst_first_stall", 64'(pipe_if.stall), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("sh_rst_stall", 64'(pipe_if.stall), 64'd0);
    check("sh_rst_write", 64'(mem_write), 64'd0);
    check("sh_rst_resp", 64'(pipe_if.resp_valid), 64'd0);
    @(posedge clk); #1;
    pipe_if.req_valid = 1'b0;
    rst_n = 1'b1;
    check("sh_rst_word800", 64'(word_at(12'h800)), 64'h0000_0000_0000_3400);
    push_ld(32'h0000_3400);
    issue("lw_after_rst", 1'b0, F3_WORD, 32'h800, 32'h0, 0);
`endif

    repeat (3) @(posedge clk);
    check("resp_q_drained", 64'(resp_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
